hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Stall-side companion to the forwarding unit: decides when the pipeline must stall or freeze because forwarding cannot supply an operand.
- Detects RAW hazards between ID-stage sources and EXE/MEM destinations, and generates a bubble request for the ID/EXE boundary.
- Runs a memory-latency FSM that freezes the whole pipeline while a load or store sits in the MEM stage.
- Keeps a saturating count of inserted bubbles for performance checks.

Parameters:
- MEM_LAT, 4, cycles the pipeline stays frozen per memory access; legal range 2..15.
- CW, 16, width of stall_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset; sampled on the clk rising edge
- src1  input  4  ID-stage first source register
- src2  input  4  ID-stage second source register
- two_src  input  1  ID instruction uses src2
- exe_wb_en  input  1  EXE-stage instruction writes back
- exe_mem_r_en  input  1  EXE-stage instruction is a load
- exe_dest  input  4  EXE-stage destination
- mem_wb_en  input  1  MEM-stage instruction writes back
- mem_dest  input  4  MEM-stage destination
- mem_r_en  input  1  MEM-stage load
- mem_w_en  input  1  MEM-stage store
- hazard  output  1  stall PC and IF/ID, force bubble into ID/EXE
- freeze  output  1  hold all pipeline registers
- mem_done  output  1  memory access completes this cycle
- stall_count  output  CW  bubbles inserted since reset

Behaviour:
Reset
- While rst==0 at a clock edge: state<=IDLE, cnt<=0, stall_count<=0.
- hazard, freeze and mem_done are forced to 0 in any cycle where rst is low.

Hazard detection (combinational)
- match_exe = exe_wb_en & (src1==exe_dest | (two_src & src2==exe_dest)).
- match_mem = mem_wb_en & (src1==mem_dest | (two_src & src2==mem_dest)).
- If two_src==0, src2 is ignored entirely.

Memory FSM
- States: IDLE, WAIT, DONE.
- IDLE:
  - mem_req = mem_r_en | mem_w_en.
  - freeze = mem_req.
  - If mem_req: load cnt<=MEM_LAT-2 and go to WAIT. Otherwise stay in IDLE.
- WAIT:
  - freeze=1.
  - If cnt==0, go to DONE. Otherwise cnt<=cnt-1.
- DONE:
  - freeze=0, mem_done=1.
  - Always return to IDLE. mem_req is not sampled in DONE, so the completing instruction cannot retrigger.
- Timing: freeze is high for exactly MEM_LAT consecutive cycles per access, and a memory instruction occupies MEM for MEM_LAT+1 cycles.
- Back-to-back memory instructions: the second access starts in the IDLE cycle immediately after DONE, so freeze has a single-cycle low gap.

Counter
- stall_count increments on each edge where hazard & ~freeze & rst.
- It saturates at all-ones and never wraps.
- A hazard held across a freeze is not counted during the freeze cycles.

Simultaneous events
- hazard and freeze may both be 1; freeze has priority in the pipeline.
- hazard stays a pure function of its inputs and is not masked by freeze.

Reset mid-operation
- A reset in WAIT or DONE returns to IDLE on that edge with freeze=0 during the reset cycle.
- After reset, a still-asserted mem_req starts a new access.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined (forwarding present): hazard = exe_mem_r_en & match_exe. Only load-use stalls remain, and match_mem is unused.
- Undefined (no forwarding): hazard = match_exe | match_mem, regardless of exe_mem_r_en.
- The FSM and counter are identical in both builds.

Test Plan:
- Reset: rst=0 for 2 cycles with mem_r_en=1 -> freeze=0, hazard=0, mem_done=0, stall_count=0; with rst=1 and mem_r_en still 1, freeze=1 in the first cycle.
- Load-use, HAZARD_FWD_EN defined: exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, src1=3 -> hazard=1, stall_count 0->1 next edge; same inputs with exe_mem_r_en=0 -> hazard=0.
- No forwarding, HAZARD_FWD_EN undefined: mem_wb_en=1, mem_dest=5, two_src=1, src2=5 -> hazard=1; two_src=0, src2=5, src1=2 -> hazard=0.
- Memory latency, MEM_LAT=4: mem_r_en=1 held -> freeze=1 for exactly 4 cycles, mem_done=1 on the 5th cycle, freeze=0 on the 5th cycle; MEM_LAT=2 -> 2 freeze cycles, then mem_done.
- Back-to-back: mem_w_en held high through two accesses -> freeze pattern 1111 0 1111 0, mem_done high twice; reset asserted during WAIT -> IDLE, freeze low during the reset cycle, new access starts the cycle after reset release.
- Saturation and freeze gating, CW=4: hazard held with freeze=0 for 20 cycles -> stall_count stops at 15; hazard=1 during an active freeze -> stall_count unchanged.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - ID/EXE/MEM hazard inputs and stall/freeze outputs of the hazard stall unit
//
// Signals:
//   src1, src2, two_src             ID-stage source operands
//   exe_wb_en, exe_mem_r_en, exe_dest   EXE-stage writer / load info
//   mem_wb_en, mem_dest, mem_r_en, mem_w_en   MEM-stage writer / access info
//   hazard, freeze, mem_done, stall_count     unit outputs
// Modports: master drives the pipeline-side inputs, slave is the stall unit.
interface hazard_stall_unit_if #(
    parameter int CW = 16
);
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic          two_src;
    logic          exe_wb_en;
    logic          exe_mem_r_en;
    logic [3:0]    exe_dest;
    logic          mem_wb_en;
    logic [3:0]    mem_dest;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          hazard;
    logic          freeze;
    logic          mem_done;
    logic [CW-1:0] stall_count;

    modport master (
        output src1, src2, two_src, exe_wb_en, exe_mem_r_en, exe_dest,
               mem_wb_en, mem_dest, mem_r_en, mem_w_en,
        input  hazard, freeze, mem_done, stall_count
    );

    modport slave (
        input  src1, src2, two_src, exe_wb_en, exe_mem_r_en, exe_dest,
               mem_wb_en, mem_dest, mem_r_en, mem_w_en,
        output hazard, freeze, mem_done, stall_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - RAW stall detection, memory-latency freeze FSM and bubble counter
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   hazard_stall_unit_if.slave (pipeline-stage inputs, hazard/freeze/mem_done/stall_count)
// Parameters:
//   MEM_LAT  cycles of freeze per memory access (2..15)
//   CW       stall_count width (must match the interface CW)
// Build option:
//   HAZARD_FWD_EN  defined when a forwarding unit exists; only load-use stalls remain.
module hazard_stall_unit #(
    parameter int MEM_LAT = 4,
    parameter int CW      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // IDLE covers the first freeze cycle and DONE follows cnt reaching zero,
    // so the WAIT preload is two short of the full latency.
    localparam logic [3:0] LOAD_CNT = 4'(MEM_LAT - 2);

    state_t        state;
    logic [3:0]    cnt;
    logic [CW-1:0] stall_q;

    logic match_exe;
    logic match_mem;
    logic hazard_raw;
    logic mem_req;
    logic freeze_c;
    logic done_c;
    logic hazard_c;
    logic unused_in;

    always_comb begin
        match_exe = bus.exe_wb_en &
                    ((bus.src1 == bus.exe_dest) | (bus.two_src & (bus.src2 == bus.exe_dest)));
        match_mem = bus.mem_wb_en &
                    ((bus.src1 == bus.mem_dest) | (bus.two_src & (bus.src2 == bus.mem_dest)));
`ifdef HAZARD_FWD_EN
        hazard_raw = bus.exe_mem_r_en & match_exe;
        unused_in  = match_mem;
`else
        hazard_raw = match_exe | match_mem;
        unused_in  = bus.exe_mem_r_en;
`endif
    end

    // Outputs are decoded from state and live inputs so the freeze asserts in
    // the very cycle the access arrives in MEM; reset low masks everything.
    always_comb begin
        mem_req  = bus.mem_r_en | bus.mem_w_en;
        freeze_c = 1'b0;
        done_c   = 1'b0;
        case (state)
            S_IDLE:  freeze_c = mem_req;
            S_WAIT:  freeze_c = 1'b1;
            S_DONE:  done_c   = 1'b1;
            default: ;
        endcase
        if (!rst) begin
            freeze_c = 1'b0;
            done_c   = 1'b0;
        end
        hazard_c = hazard_raw & rst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            stall_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        cnt   <= LOAD_CNT;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // The completing instruction is still in MEM here; ignoring
                // mem_req keeps it from starting a second access.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Bubbles only count when the pipeline actually advances.
            if (hazard_c && !freeze_c && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.hazard      = hazard_c;
    assign bus.freeze      = freeze_c;
    assign bus.mem_done    = done_c;
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed-vector self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CW(4))  bus0 ();
    hazard_stall_unit_if #(.CW(16)) bus1 ();

    hazard_stall_unit #(.MEM_LAT(4), .CW(4)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    hazard_stall_unit #(.MEM_LAT(2), .CW(16)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int passed = 0;
    int total  = 0;
    int exp_cnt;

    // Hazard vectors: exe_wb_en, exe_mem_r_en, exe_dest, src1, src2, two_src, mem_wb_en, mem_dest
    logic       v_we  [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    logic       v_rd  [8] = '{1, 0, 0, 0, 1, 1, 1, 0};
    logic [3:0] v_ed  [8] = '{3, 3, 0, 0, 7, 7, 3, 0};
    logic [3:0] v_s1  [8] = '{3, 3, 2, 2, 1, 1, 3, 9};
    logic [3:0] v_s2  [8] = '{0, 0, 5, 5, 7, 7, 0, 0};
    logic       v_two [8] = '{0, 0, 1, 0, 1, 0, 0, 0};
    logic       v_mwe [8] = '{0, 0, 1, 1, 0, 0, 0, 1};
    logic [3:0] v_md  [8] = '{0, 0, 5, 5, 0, 0, 0, 9};
    logic       v_hz_fwd [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    logic       v_hz_raw [8] = '{1, 1, 1, 0, 1, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear0();
        bus0.src1 = 0; bus0.src2 = 0; bus0.two_src = 0;
        bus0.exe_wb_en = 0; bus0.exe_mem_r_en = 0; bus0.exe_dest = 0;
        bus0.mem_wb_en = 0; bus0.mem_dest = 0; bus0.mem_r_en = 0; bus0.mem_w_en = 0;
    endtask

    task automatic clear1();
        bus1.src1 = 0; bus1.src2 = 0; bus1.two_src = 0;
        bus1.exe_wb_en = 0; bus1.exe_mem_r_en = 0; bus1.exe_dest = 0;
        bus1.mem_wb_en = 0; bus1.mem_dest = 0; bus1.mem_r_en = 0; bus1.mem_w_en = 0;
    endtask

    task automatic drive_vec(input int k);
        bus0.exe_wb_en = v_we[k]; bus0.exe_mem_r_en = v_rd[k]; bus0.exe_dest = v_ed[k];
        bus0.src1 = v_s1[k]; bus0.src2 = v_s2[k]; bus0.two_src = v_two[k];
        bus0.mem_wb_en = v_mwe[k]; bus0.mem_dest = v_md[k];
    endtask

    initial begin
        rst = 1'b0;
        clear0();
        clear1();
        // Reset with a memory request and a matching load-use pattern present.
        bus0.mem_r_en = 1; bus0.exe_wb_en = 1; bus0.exe_mem_r_en = 1;
        step();
        step();
        check("rst_freeze", bus0.freeze, 0);
        check("rst_hazard", bus0.hazard, 0);
        check("rst_done", bus0.mem_done, 0);
        check("rst_count", bus0.stall_count, 0);

        bus0.exe_wb_en = 0; bus0.exe_mem_r_en = 0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lat4_freeze_%0d", i), bus0.freeze, (i < 4) ? 1 : 0);
            check($sformatf("lat4_done_%0d", i), bus0.mem_done, (i == 4) ? 1 : 0);
            if (i == 4) bus0.mem_r_en = 0;
            step();
        end
        check("lat4_idle_freeze", bus0.freeze, 0);
        check("lat4_idle_done", bus0.mem_done, 0);

        exp_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive_vec(k);
            #1;
            check($sformatf("vec%0d_hazard", k), bus0.hazard, FWD ? v_hz_fwd[k] : v_hz_raw[k]);
            step();
            if ((FWD ? v_hz_fwd[k] : v_hz_raw[k]) && exp_cnt < 15) exp_cnt++;
            check($sformatf("vec%0d_count", k), bus0.stall_count, exp_cnt);
        end

        // Load-use hazard held across a memory freeze.
        drive_vec(0);
        bus0.mem_r_en = 1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("gate_freeze_%0d", i), bus0.freeze, (i < 4) ? 1 : 0);
            check($sformatf("gate_hazard_%0d", i), bus0.hazard, 1);
            if (i == 4) bus0.mem_r_en = 0;
            step();
            if (i == 4 && exp_cnt < 15) exp_cnt++;
            check($sformatf("gate_count_%0d", i), bus0.stall_count, exp_cnt);
        end

        for (int i = 0; i < 20; i++) step();
        check("sat_count", bus0.stall_count, 15);
        clear0();

        bus0.mem_w_en = 1;
        #1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("b2b_freeze_%0d", i), bus0.freeze, (i % 5 != 4) ? 1 : 0);
            check($sformatf("b2b_done_%0d", i), bus0.mem_done, (i % 5 == 4) ? 1 : 0);
            if (i == 9) bus0.mem_w_en = 0;
            step();
        end
        check("b2b_idle_freeze", bus0.freeze, 0);

        bus1.mem_r_en = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lat2_freeze_%0d", i), bus1.freeze, (i < 2) ? 1 : 0);
            check($sformatf("lat2_done_%0d", i), bus1.mem_done, (i == 2) ? 1 : 0);
            if (i == 2) bus1.mem_r_en = 0;
            step();
        end
        check("lat2_idle_freeze", bus1.freeze, 0);

        // Reset while in WAIT, with the request still held.
        bus0.mem_r_en = 1;
        #1;
        step();
        check("mid_wait_freeze", bus0.freeze, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_freeze", bus0.freeze, 0);
        check("mid_rst_done", bus0.mem_done, 0);
        step();
        check("mid_rst_count", bus0.stall_count, 0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("post_rst_freeze_%0d", i), bus0.freeze, (i < 4) ? 1 : 0);
            check($sformatf("post_rst_done_%0d", i), bus0.mem_done, (i == 4) ? 1 : 0);
            if (i == 4) bus0.mem_r_en = 0;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
